// File: rtl/param_delay_pipe.sv
// param_delay_pipe: multi-stage register delay line with a programmable output tap.
// Data and valid move one stage per enabled clock. The tap select picks which stage
// drives the output, so latency = tap_sel+1 enabled clocks. Supports stall (en),
// synchronous flush, and a count of occupied stages.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   en         shift enable; low holds every stage and the count
//   flush      synchronous clear of all stages; the input sample that cycle is dropped
//   in_valid   input sample valid
//   in_data    input sample (WIDTH bits)
//   tap_sel    output stage index (TAPW bits), clamped to DEPTH-1
//   out_valid  valid bit of the selected stage
//   out_data   data of the selected stage, zero when out_valid is low
//   occupancy  number of stages holding valid data (CNTW bits)
//   full       occupancy == DEPTH
module param_delay_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned TAPW = $clog2(DEPTH),
    localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAPW-1:0]  tap_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  occupancy,
    output logic             full
);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_next;
    logic [TAPW-1:0]  idx;

    // One sample enters while the oldest stage's sample leaves; cannot exceed DEPTH
    // because a full pipe always has its last stage valid.
    assign cnt_next = cnt + CNTW'(in_valid) - CNTW'(v[DEPTH-1]);

    // Shift register: rst and flush clear everything, en advances, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                d[i] <= '0;
            end
            v   <= '0;
            cnt <= '0;
        end else if (en) begin
            d[0] <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                d[i] <= d[i-1];
            end
            v   <= {v[DEPTH-2:0], in_valid};
            cnt <= cnt_next;
        end
    end

    // Clamp out-of-range taps (possible when DEPTH is not a power of two).
    always_comb begin
        idx = tap_sel;
        if (32'(tap_sel) >= DEPTH) begin
            idx = TAPW'(DEPTH - 1);
        end
    end

    // Output mux; stage 0 loads data even for invalid samples, so mask it here.
    always_comb begin
        out_valid = v[idx];
        out_data  = '0;
        if (v[idx]) begin
            out_data = d[idx];
        end
    end

    assign occupancy = cnt;
    assign full      = (cnt == CNTW'(DEPTH));

endmodule

// File: tb/tb_param_delay_pipe.sv
// Bench for param_delay_pipe: a DEPTH=4 and a DEPTH=5 instance share the stimulus.
// Expected outputs are queued with the enabled-edge number at which they are due
// and popped when that edge is reached; occupancy is derived from capture edges.
module tb_param_delay_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic [1:0] tap4;
    logic [2:0] tap5;
    logic       ov4, ov5, full4, full5;
    logic [3:0] od4, od5;
    logic [2:0] occ4, occ5;

    param_delay_pipe #(.WIDTH(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .tap_sel(tap4),
        .out_valid(ov4), .out_data(od4), .occupancy(occ4), .full(full4)
    );

    param_delay_pipe #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .tap_sel(tap5),
        .out_valid(ov5), .out_data(od5), .occupancy(occ5), .full(full5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        int         due;
    } ent_t;

    ent_t  q4[$];
    ent_t  q5[$];
    int    inflight[$];
    int    en_edges;
    int    tap4_eff;
    int    tap5_eff;
    logic  exp_v4, exp_v5;
    logic [3:0] exp_d4, exp_d5;
    int    n_checks;
    int    n_pass;
    string phase;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s %s: got %0d expected %0d", phase, tag, got, exp);
        end
    endtask

    task automatic set_taps(input int t4, input int t5);
        tap4     = 2'(t4);
        tap5     = 3'(t5);
        tap4_eff = t4;
        tap5_eff = (t5 > 4) ? 4 : t5;
    endtask

    // Drive one cycle, update the model, then compare both instances after the edge.
    task automatic step(input logic r, input logic e, input logic f,
                        input logic iv, input logic [3:0] id);
        ent_t ent;
        int   o4;
        int   o5;
        rst      = r;
        en       = e;
        flush    = f;
        in_valid = iv;
        in_data  = id;
        if (r || f) begin
            q4.delete();
            q5.delete();
            inflight.delete();
            exp_v4 = 1'b0; exp_d4 = 4'h0;
            exp_v5 = 1'b0; exp_d5 = 4'h0;
        end else if (e) begin
            en_edges++;
            if (iv) begin
                ent.data = id;
                ent.due  = en_edges + tap4_eff;
                q4.push_back(ent);
                ent.due  = en_edges + tap5_eff;
                q5.push_back(ent);
                inflight.push_back(en_edges);
            end
        end
        @(posedge clk);
        #1;
        if (!(r || f) && e) begin
            exp_v4 = 1'b0; exp_d4 = 4'h0;
            if (q4.size() > 0 && q4[0].due == en_edges) begin
                exp_v4 = 1'b1;
                exp_d4 = q4[0].data;
                void'(q4.pop_front());
            end
            exp_v5 = 1'b0; exp_d5 = 4'h0;
            if (q5.size() > 0 && q5[0].due == en_edges) begin
                exp_v5 = 1'b1;
                exp_d5 = q5[0].data;
                void'(q5.pop_front());
            end
            while (inflight.size() > 0 && inflight[0] <= en_edges - 5) begin
                void'(inflight.pop_front());
            end
        end
        o4 = 0;
        o5 = 0;
        foreach (inflight[i]) begin
            if (inflight[i] > en_edges - 4) o4++;
            if (inflight[i] > en_edges - 5) o5++;
        end
        check("out_valid4", int'(ov4), int'(exp_v4));
        check("out_data4", int'(od4), int'(exp_d4));
        check("occupancy4", int'(occ4), o4);
        check("full4", int'(full4), int'(o4 == 4));
        check("out_valid5", int'(ov5), int'(exp_v5));
        check("out_data5", int'(od5), int'(exp_d5));
        check("occupancy5", int'(occ5), o5);
        check("full5", int'(full5), int'(o5 == 5));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        en_edges = 0;
        rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0;
        set_taps(3, 7);

        phase = "reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

        phase = "stream_tap3";
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'(i));
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        phase = "stall_tap0";
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        set_taps(0, 7);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'hB);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        phase = "flush_full";
        set_taps(3, 7);
        for (int i = 6; i <= 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        phase = "bubbles_tap1";
        set_taps(1, 7);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h9);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        phase = "rst_midstream";
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'(i + 1));
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'hE);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h7);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

        phase = "random_tap2";
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        set_taps(2, 2);
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
                 1'($urandom), 4'($urandom));
        end

        phase = "random_tap1_7";
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        set_taps(1, 7);
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 3) != 0), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
